tdm_demux_1t4: RTL and testbench

- Receive end of the 4:1 selection path. It accepts a time-division-multiplexed word stream carrying lanes A, B, C, D in slot order 0..3. It rebuilds the four lanes as parallel registered outputs.
- Frame boundary is marked by Sync on slot 0.
- Sits downstream of the 4:1 mux/serializer. Together they give a loopback path that lets the comparison bench check mux-then-demux round trips.

---
 rtl/tdm_demux_1t4_pkg.sv | 13 +
 rtl/tdm_demux_1t4_slot_ctr.sv | 24 ++
 rtl/tdm_demux_1t4.sv | 100 ++++++++++
 tb/tb_tdm_demux_1t4.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_1t4_pkg.sv
// Shared slot and state encodings for the 4-lane TDM demultiplexer and its
// matching serializer.
package tdm_demux_1t4_pkg;

   localparam logic [1:0] SLOT_A = 2'b00;
   localparam logic [1:0] SLOT_B = 2'b01;
   localparam logic [1:0] SLOT_C = 2'b10;
   localparam logic [1:0] SLOT_D = 2'b11;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;

endpackage

// File: rtl/tdm_demux_1t4_slot_ctr.sv
// 2-bit slot counter: clear to slot A, load to slot B on a frame start,
// otherwise step by one when enabled.
module tdm_slot_ctr
   import tdm_demux_1t4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       clr,
   input  logic       inc,
   output logic [1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= SLOT_A;
      end else if (load) begin
         q <= SLOT_B;
      end else if (inc) begin
         q <= q + 2'd1;
      end
   end

endmodule

// File: rtl/tdm_demux_1t4.sv
// Receive side of the 4:1 TDM path: rebuilds lanes A..D from a slot-ordered
// word stream framed by Sync on slot 0.
module tdm_demux_1t4
   import tdm_demux_1t4_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] Din,
   input  logic         Valid,
   input  logic         Sync,
   output logic [W-1:0] A,
   output logic [W-1:0] B,
   output logic [W-1:0] C,
   output logic [W-1:0] D,
   output logic         Frame_valid,
   output logic [1:0]   Sel,
   output logic         Err
);

   // Handshake: a word is consumed on every edge where Valid=1; there is no
   // back-pressure. Sync is ignored unless Valid=1.
   logic [0:0]   state;
   logic [W-1:0] s0, s1, s2;
   logic         ctr_load, ctr_clr, ctr_inc;
   logic [1:0]   slot;

   assign Sel = slot;

   // An early Sync restarts the frame, so a load is valid in either state.
   always_comb begin
      ctr_load = Valid & Sync;
      ctr_clr  = 1'b0;
      ctr_inc  = 1'b0;
      if (state == ST_RECV && Valid && !Sync) begin
         if (slot == SLOT_D) ctr_clr = 1'b1;
         else                ctr_inc = 1'b1;
      end
   end

   tdm_slot_ctr u_slot_ctr (
      .clk  (clk),
      .rst  (rst),
      .load (ctr_load),
      .clr  (ctr_clr),
      .inc  (ctr_inc),
      .q    (slot)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         s0          <= '0;
         s1          <= '0;
         s2          <= '0;
         A           <= '0;
         B           <= '0;
         C           <= '0;
         D           <= '0;
         Frame_valid <= 1'b0;
         Err         <= 1'b0;
      end else begin
         Frame_valid <= 1'b0;
         Err         <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (Valid && Sync) begin
                  s0    <= Din;
                  state <= ST_RECV;
               end
            end
            ST_RECV: begin
               if (Valid) begin
                  if (Sync) begin
                     Err <= 1'b1;
                     s0  <= Din;
                  end else begin
                     case (slot)
                        SLOT_B: s1 <= Din;
                        SLOT_C: s2 <= Din;
                        SLOT_D: begin
                           A           <= s0;
                           B           <= s1;
                           C           <= s2;
                           D           <= Din;
                           Frame_valid <= 1'b1;
                           state       <= ST_IDLE;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tdm_demux_1t4.sv
// Bench for tdm_demux_1t4: directed vector table followed by a randomized run
// against a queue-based frame model.
module tb_tdm_demux_1t4;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din;
   logic         valid;
   logic         sync;
   logic [W-1:0] a, b, c, d;
   logic         frame_valid;
   logic [1:0]   sel;
   logic         err;

   tdm_demux_1t4 #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .Din         (din),
      .Valid       (valid),
      .Sync        (sync),
      .A           (a),
      .B           (b),
      .C           (c),
      .D           (d),
      .Frame_valid (frame_valid),
      .Sel         (sel),
      .Err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rst;
      logic         valid;
      logic         sync;
      logic [W-1:0] din;
      logic [W-1:0] ea, eb, ec, ed;
      logic         efv;
      logic [1:0]   esel;
      logic         eerr;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model: the partial frame is simply a queue of accepted words.
   logic [W-1:0] part_q[$];
   logic [W-1:0] m_a, m_b, m_c, m_d;
   logic         m_fv, m_err;
   logic [1:0]   m_sel;

   task automatic add(input logic r, input logic v, input logic s, input int dv,
                      input int xa, input int xb, input int xc, input int xd,
                      input logic fv, input int sl, input logic er);
      vec_t t;
      t.rst = r; t.valid = v; t.sync = s; t.din = W'(dv);
      t.ea = W'(xa); t.eb = W'(xb); t.ec = W'(xc); t.ed = W'(xd);
      t.efv = fv; t.esel = 2'(sl); t.eerr = er;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic r, input logic v, input logic s, input logic [W-1:0] dv);
      rst = r; valid = v; sync = s; din = dv;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] xc, input logic [W-1:0] xd, input logic fv,
                        input logic [1:0] sl, input logic er);
      n_vec++;
      if ({a, b, c, d, frame_valid, sel, err} !== {xa, xb, xc, xd, fv, sl, er}) begin
         n_bad++;
         $display("FAIL %s: got A=%h B=%h C=%h D=%h fv=%b sel=%b err=%b, want A=%h B=%h C=%h D=%h fv=%b sel=%b err=%b",
                  name, a, b, c, d, frame_valid, sel, err, xa, xb, xc, xd, fv, sl, er);
      end
   endtask

   task automatic model_step(input logic r, input logic v, input logic s, input logic [W-1:0] dv);
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (r) begin
         part_q.delete();
         m_a = '0; m_b = '0; m_c = '0; m_d = '0;
      end else if (v) begin
         if (s) begin
            if (part_q.size() != 0) m_err = 1'b1;
            part_q.delete();
            part_q.push_back(dv);
         end else if (part_q.size() != 0) begin
            part_q.push_back(dv);
            if (part_q.size() == 4) begin
               m_a = part_q[0]; m_b = part_q[1]; m_c = part_q[2]; m_d = part_q[3];
               m_fv = 1'b1;
               part_q.delete();
            end
         end
      end
      m_sel = 2'(part_q.size());
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; sync = 1'b0; din = '0;

      // rst v s din    A  B  C  D  fv sel err
      add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      // frame 0,1,0,1
      add(0, 1, 1, 0,   0, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0, 1,   0, 0, 0, 0, 0, 2, 0);
      add(0, 1, 0, 0,   0, 0, 0, 0, 0, 3, 0);
      add(0, 1, 0, 1,   0, 1, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);
      // same frame with a 3-cycle gap after slot 1
      add(0, 1, 1, 0,   0, 1, 0, 1, 0, 1, 0);
      add(0, 1, 0, 1,   0, 1, 0, 1, 0, 2, 0);
      add(0, 0, 0, 0,   0, 1, 0, 1, 0, 2, 0);
      add(0, 0, 1, 5,   0, 1, 0, 1, 0, 2, 0);
      add(0, 0, 0, 0,   0, 1, 0, 1, 0, 2, 0);
      add(0, 1, 0, 0,   0, 1, 0, 1, 0, 3, 0);
      add(0, 1, 0, 1,   0, 1, 0, 1, 1, 0, 0);
      // 1,1,1,1 then zero-gap 0,0,1,0
      add(0, 1, 1, 1,   0, 1, 0, 1, 0, 1, 0);
      add(0, 1, 0, 1,   0, 1, 0, 1, 0, 2, 0);
      add(0, 1, 0, 1,   0, 1, 0, 1, 0, 3, 0);
      add(0, 1, 0, 1,   1, 1, 1, 1, 1, 0, 0);
      add(0, 1, 1, 0,   1, 1, 1, 1, 0, 1, 0);
      add(0, 1, 0, 0,   1, 1, 1, 1, 0, 2, 0);
      add(0, 1, 0, 1,   1, 1, 1, 1, 0, 3, 0);
      add(0, 1, 0, 0,   0, 0, 1, 0, 1, 0, 0);
      // early sync: 1,1 then Sync 0,0,1,1
      add(0, 1, 1, 1,   0, 0, 1, 0, 0, 1, 0);
      add(0, 1, 0, 1,   0, 0, 1, 0, 0, 2, 0);
      add(0, 1, 1, 0,   0, 0, 1, 0, 0, 1, 1);
      add(0, 1, 0, 0,   0, 0, 1, 0, 0, 2, 0);
      add(0, 1, 0, 1,   0, 0, 1, 0, 0, 3, 0);
      add(0, 1, 0, 1,   0, 0, 1, 1, 1, 0, 0);
      // unsynced words while idle
      add(0, 1, 0, 1,   0, 0, 1, 1, 0, 0, 0);
      add(0, 1, 0, 0,   0, 0, 1, 1, 0, 0, 0);
      add(0, 1, 0, 9,   0, 0, 1, 1, 0, 0, 0);
      // reset after slot 2, then frame 1,0,1,0
      add(0, 1, 1, 1,   0, 0, 1, 1, 0, 1, 0);
      add(0, 1, 0, 0,   0, 0, 1, 1, 0, 2, 0);
      add(0, 1, 0, 1,   0, 0, 1, 1, 0, 3, 0);
      add(1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 1,   0, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0, 0,   0, 0, 0, 0, 0, 2, 0);
      add(0, 1, 0, 1,   0, 0, 0, 0, 0, 3, 0);
      add(0, 1, 0, 0,   1, 0, 1, 0, 1, 0, 0);
      add(0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0);
      // wide data through all lanes
      add(0, 1, 1, 10,  1, 0, 1, 0, 0, 1, 0);
      add(0, 1, 0, 11,  1, 0, 1, 0, 0, 2, 0);
      add(0, 1, 0, 12,  1, 0, 1, 0, 0, 3, 0);
      add(0, 1, 0, 13,  10, 11, 12, 13, 1, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].valid, vecs[i].sync, vecs[i].din);
         check($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed,
               vecs[i].efv, vecs[i].esel, vecs[i].eerr);
      end

      // Randomized run against the model, starting from a fresh reset.
      model_step(1'b1, 1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, 1'b0, '0);
      check("rand_rst", m_a, m_b, m_c, m_d, m_fv, m_sel, m_err);
      for (int i = 0; i < 3000; i++) begin
         logic         r, v, s;
         logic [W-1:0] dv;
         r  = ($urandom_range(0, 199) == 0);
         v  = ($urandom_range(0, 9) < 7);
         s  = ($urandom_range(0, 5) == 0);
         dv = W'($urandom);
         model_step(r, v, s, dv);
         drive(r, v, s, dv);
         check($sformatf("rand%0d", i), m_a, m_b, m_c, m_d, m_fv, m_sel, m_err);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
